// File: rtl/apb_master_if.sv
// Command/response and APB bus bundle for apb_master.
// The master modport is the bridge's view; the slave modport is the view
// of whatever sits on the other side (command source plus APB slave).
interface apb_master_if #(
  parameter int AMBA_ADDR_WIDTH = 32,
  parameter int AMBA_WORD       = 32
);
  // Command side
  logic                       cmd_valid;
  logic                       cmd_ready;
  logic                       cmd_write;
  logic [AMBA_ADDR_WIDTH-1:0] cmd_addr;
  logic [AMBA_WORD-1:0]       cmd_wdata;
  // Response side
  logic                       rsp_valid;
  logic                       rsp_err;
  logic [AMBA_WORD-1:0]       rsp_rdata;
  // APB side
  logic                       PSEL;
  logic                       PENABLE;
  logic                       PWRITE;
  logic [AMBA_ADDR_WIDTH-1:0] PADDR;
  logic [AMBA_WORD-1:0]       PWDATA;
  logic [AMBA_WORD-1:0]       PRDATA;
  logic                       PREADY;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA, PREADY,
    output cmd_ready, rsp_valid, rsp_err, rsp_rdata,
           PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA, PREADY,
    input  cmd_ready, rsp_valid, rsp_err, rsp_rdata,
           PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );
endinterface

// File: rtl/apb_master.sv
// Single-outstanding command-to-APB bridge. Accepts one command in IDLE,
// runs SETUP/ACCESS on APB (optionally RDCAP for registered-read slaves),
// and returns a one-cycle response pulse. A wait-state counter aborts
// transfers whose slave never raises PREADY.
module apb_master #(
  parameter int AMBA_ADDR_WIDTH = 32,
  parameter int AMBA_WORD       = 32,
  parameter int TIMEOUT         = 16,
  parameter int RD_LATE         = 1
) (
  input logic          clk,
  input logic          rst,
  apb_master_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RDCAP
  } state_e;

  localparam int WAIT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_e                     state_q;
  logic                       ready_q;
  logic                       psel_q;
  logic                       penable_q;
  logic                       pwrite_q;
  logic [AMBA_ADDR_WIDTH-1:0] paddr_q;
  logic [AMBA_WORD-1:0]       pwdata_q;
  logic                       rsp_valid_q;
  logic                       rsp_err_q;
  logic [AMBA_WORD-1:0]       rsp_rdata_q;
  logic [WAIT_W-1:0]          wait_q;
  logic                       timeout_hit;

  // Abort when this wait cycle would bring the counter up to TIMEOUT.
  assign timeout_hit = (TIMEOUT > 0) && (wait_q == WAIT_LAST);

  // Transfer FSM; every bus and response output is a register here.
  // NOTE: all state uses non-blocking assignments so every branch reads the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      ready_q     <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      wait_q      <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.cmd_valid && ready_q) begin
            // Word-align the address; the APB fields double as the command latch.
            paddr_q  <= {bus.cmd_addr[AMBA_ADDR_WIDTH-1:2], 2'b00};
            pwrite_q <= bus.cmd_write;
            pwdata_q <= bus.cmd_wdata;
            psel_q   <= 1'b1;
            ready_q  <= 1'b0;
            state_q  <= SETUP;
          end else begin
            // Held low through reset, raised on the first clock after it.
            ready_q <= 1'b1;
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          wait_q    <= '0;
          state_q   <= ACCESS;
        end
        ACCESS: begin
          if (bus.PREADY) begin
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            if (pwrite_q) begin
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b0;
              rsp_rdata_q <= '0;
              ready_q     <= 1'b1;
              state_q     <= IDLE;
            end else if (RD_LATE != 0) begin
              state_q <= RDCAP;
            end else begin
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b0;
              rsp_rdata_q <= bus.PRDATA;
              ready_q     <= 1'b1;
              state_q     <= IDLE;
            end
          end else if (timeout_hit) begin
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_rdata_q <= '0;
            ready_q     <= 1'b1;
            state_q     <= IDLE;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        RDCAP: begin
          // Registered-read slaves present PRDATA one cycle after ACCESS.
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= 1'b0;
          rsp_rdata_q <= bus.PRDATA;
          ready_q     <= 1'b1;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready = ready_q;
  assign bus.PSEL      = psel_q;
  assign bus.PENABLE   = penable_q;
  assign bus.PWRITE    = pwrite_q;
  assign bus.PADDR     = paddr_q;
  assign bus.PWDATA    = pwdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;

endmodule
